updown_cnt_tracker: RTL
=======================

# updown_cnt_tracker

Sequence tracker that sits directly downstream of the 4-bit up/down (triangle) counter. It samples the counter's output each valid cycle and locks onto the 0→15→0 triangle sequence. It reports the current direction and emits peak and trough pulses. It counts complete periods and flags any sample that breaks the sequence. The counter block has no error detection, so the bench scoreboard and system-level status logic use this block as the counter's health monitor.

## Interface

Parameters:
- PER_W, 8, width of the period counter; wraps modulo 2^PER_W
- ERR_W, 8, width of the error counter; saturates at all-ones

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- cnt_in  input  4  sample of the counter output
- cnt_vld  input  1  cnt_in is valid this cycle; the sample is ignored when low
- clr  input  1  synchronous clear of period_cnt and err_cnt only
- locked  output  1  tracker is in UP or DOWN state
- dir  output  1  0 = counting up, 1 = counting down; valid only when locked
- peak  output  1  one-cycle pulse: 15→14 transition accepted
- trough  output  1  one-cycle pulse: 0→1 transition accepted
- err  output  1  one-cycle pulse: sequence violation detected
- period_cnt  output  PER_W  number of accepted troughs since reset/clr
- err_cnt  output  ERR_W  number of violations since reset/clr (see Configuration)

## Operation

- Internal state: FSM {SYNC, ACQ, UP, DOWN} and a 4-bit register prev.
- Cycles with cnt_vld=0: no state change and no pulses; prev holds.
- SYNC: on a valid sample, prev←cnt_in, go to ACQ. No pulses are emitted.
- ACQ (valid sample s):
  - s==prev: stay in ACQ, no error.
  - s==prev+1 (prev≠15), or prev==0 and s==1: go to UP.
  - s==prev−1 (prev≠0), or prev==15 and s==14: go to DOWN.
  - Any other value: err pulse, stay in ACQ.
  - prev←s in every case.
  - No peak or trough pulses are emitted from ACQ.
- UP (valid sample s):
  - Expected value is prev+1 if prev≠15. If prev==15, the expected value is 14; on a match, go to DOWN and pulse peak.
- DOWN (valid sample s):
  - Expected value is prev−1 if prev≠0. If prev==0, the expected value is 1; on a match, go to UP, pulse trough, and increment period_cnt.
- Mismatch in UP or DOWN, including a repeated value: err pulse, go to ACQ, prev←s, err_cnt increments (saturating).
- Arithmetic:
  - All 4-bit comparisons are explicit; there is no modulo-16 wrap between 15 and 0.
  - A 15→0 or 0→15 step is an error.
- dir=0 in UP, 1 in DOWN. dir holds its last value in SYNC/ACQ and is 0 after reset.
- clr zeroes period_cnt and err_cnt. clr wins over a same-cycle increment. clr does not affect the FSM.

## Timing

- All outputs are registered. A sample taken at rising edge N is reflected in the outputs after edge N (1-cycle latency).
- peak, trough and err are high for exactly one cycle per event. They never assert together.
- Reset values: locked=0, dir=0, peak=0, trough=0, err=0, period_cnt=0, err_cnt=0, FSM=SYNC, prev=0.
- rst takes precedence over cnt_vld and clr. Asserting rst mid-sequence returns all outputs to reset values after the next edge.
- From reset with a legal stream, locked rises after the 2nd valid sample.
- One full counter period is 30 valid samples (trough to trough).

## Configuration

- UPDOWN_TRACKER_ERRCNT_EN defined: the err_cnt register and its saturating increment are compiled in.
- UPDOWN_TRACKER_ERRCNT_EN undefined: there is no err_cnt register and err_cnt is tied to 0.
- err, locked and all other behaviour are identical in both builds.

## Test plan

- Reset, then a legal stream 0,1,…,15,14,…,0,1 with cnt_vld=1:
  - locked=1 and dir=0 after the 2nd sample.
  - peak pulses after sample 14 and dir becomes 1.
  - trough pulses after the final 1; period_cnt=1, err=0 throughout.
- Locked UP stream 4,5,6,8,9,10:
  - err pulses after 8, err_cnt=1, locked=0.
  - Re-locks with dir=0 after 9; no peak or trough.
- Stream 13,14 then cnt_vld=0 for 5 cycles, then 15,14:
  - No err during the gap.
  - peak after 14; dir=1.
- ERR_W=2 with 5 injected violations: err_cnt saturates at 3. A clr pulse then gives err_cnt=0.
- Locked at DOWN 1,0,1 with clr asserted on the cycle the final 1 is sampled: trough pulses and period_cnt=0.
- rst asserted mid-UP at sample 7:
  - All outputs are 0 after the edge.
  - Next samples 0,1 give locked=1.
  - Build without UPDOWN_TRACKER_ERRCNT_EN: err pulses still occur and err_cnt stays 0.

Source files
------------

// File: rtl/updown_cnt_tracker_if.sv
// Sample/status bundle between the triangle counter tap and the tracker.
// The tracker drives the status side through the slave modport.
interface updown_cnt_tracker_if #(
  parameter int PER_W = 8,
  parameter int ERR_W = 8
) ();
  logic [3:0]       cnt_in;
  logic             cnt_vld;
  logic             clr;
  logic             locked;
  logic             dir;
  logic             peak;
  logic             trough;
  logic             err;
  logic [PER_W-1:0] period_cnt;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output cnt_in, cnt_vld, clr,
    input  locked, dir, peak, trough, err, period_cnt, err_cnt
  );

  modport slave (
    input  cnt_in, cnt_vld, clr,
    output locked, dir, peak, trough, err, period_cnt, err_cnt
  );
endinterface

// File: rtl/updown_cnt_tracker.sv
// Health monitor for the 4-bit 0->15->0 triangle counter: locks onto the
// sequence, reports direction, peak/trough pulses, periods and violations.
// Define UPDOWN_TRACKER_ERRCNT_EN to build the saturating err_cnt register.
module updown_cnt_tracker #(
  parameter int PER_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  updown_cnt_tracker_if.slave bus
);

  typedef enum logic [1:0] {SYNC, ACQ, UP, DOWN} state_t;

  state_t           state_reg;
  logic [3:0]       prev_reg;
  logic             locked_reg;
  logic             dir_reg;
  logic             peak_reg;
  logic             trough_reg;
  logic             err_reg;
  logic [PER_W-1:0] period_reg;

  logic [3:0] up_exp;
  logic [3:0] dn_exp;
  logic       acq_up;
  logic       acq_dn;
  logic       viol;
  logic       trough_hit;

  // Turnaround points are explicit: 15 is followed by 14 and 0 by 1, never a wrap.
  always_comb begin
    up_exp     = (prev_reg == 4'd15) ? 4'd14 : prev_reg + 4'd1;
    dn_exp     = (prev_reg == 4'd0)  ? 4'd1  : prev_reg - 4'd1;
    acq_up     = (prev_reg != 4'd15) && (bus.cnt_in == prev_reg + 4'd1);
    acq_dn     = (prev_reg != 4'd0)  && (bus.cnt_in == prev_reg - 4'd1);
    viol       = 1'b0;
    trough_hit = 1'b0;
    if (bus.cnt_vld) begin
      case (state_reg)
        ACQ:     viol = (bus.cnt_in != prev_reg) && !acq_up && !acq_dn;
        UP:      viol = (bus.cnt_in != up_exp);
        DOWN:    viol = (bus.cnt_in != dn_exp);
        default: viol = 1'b0;
      endcase
      trough_hit = (state_reg == DOWN) && (prev_reg == 4'd0) && (bus.cnt_in == 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= SYNC;
      prev_reg   <= 4'd0;
      locked_reg <= 1'b0;
      dir_reg    <= 1'b0;
      peak_reg   <= 1'b0;
      trough_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      peak_reg   <= 1'b0;
      trough_reg <= 1'b0;
      err_reg    <= 1'b0;
      if (bus.cnt_vld) begin
        prev_reg <= bus.cnt_in;
        case (state_reg)
          SYNC: begin
            state_reg  <= ACQ;
            locked_reg <= 1'b0;
          end
          ACQ: begin
            if (acq_up) begin
              state_reg  <= UP;
              locked_reg <= 1'b1;
              dir_reg    <= 1'b0;
            end else if (acq_dn) begin
              state_reg  <= DOWN;
              locked_reg <= 1'b1;
              dir_reg    <= 1'b1;
            end else if (viol) begin
              err_reg <= 1'b1;
            end
          end
          UP: begin
            if (viol) begin
              state_reg  <= ACQ;
              locked_reg <= 1'b0;
              err_reg    <= 1'b1;
            end else if (prev_reg == 4'd15) begin
              state_reg <= DOWN;
              dir_reg   <= 1'b1;
              peak_reg  <= 1'b1;
            end
          end
          DOWN: begin
            if (viol) begin
              state_reg  <= ACQ;
              locked_reg <= 1'b0;
              err_reg    <= 1'b1;
            end else if (trough_hit) begin
              state_reg  <= UP;
              dir_reg    <= 1'b0;
              trough_reg <= 1'b1;
            end
          end
          default: begin
            state_reg  <= SYNC;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // clr overrides a same-cycle trough increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      period_reg <= '0;
    end else if (trough_hit) begin
      period_reg <= period_reg + 1'b1;
    end
  end

`ifdef UPDOWN_TRACKER_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      err_cnt_reg <= '0;
    end else if (viol && (err_cnt_reg != {ERR_W{1'b1}})) begin
      err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign bus.err_cnt = '0;
`endif

  assign bus.locked     = locked_reg;
  assign bus.dir        = dir_reg;
  assign bus.peak       = peak_reg;
  assign bus.trough     = trough_reg;
  assign bus.err        = err_reg;
  assign bus.period_cnt = period_reg;

endmodule
